// File: rtl/qpsk_symbol_upsampler.sv
// QPSK symbol upsampler: buffers mapper symbols in a small FIFO and re-emits
// each one as SPS samples (zero-stuffed or held) on the DAC sample strobe.
module qpsk_symbol_upsampler #(
  parameter int SPS         = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int START_LEVEL = 2,
  parameter int HOLD_MODE   = 0
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [31:0]                   i_data,
  input  logic                          i_valid,
  input  logic                          i_sample_en,
  output logic [31:0]                   o_data,
  output logic                          o_valid,
  output logic                          o_underflow,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int DATA_W = 16;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int LW     = AW + 1;
  localparam int PW     = (SPS > 1) ? $clog2(SPS) : 1;

  localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] START_L     = LW'(START_LEVEL);
  localparam logic [PW-1:0] LAST_PH     = PW'(SPS - 1);
  localparam logic [PW-1:0] PH_AFTER_LD = PW'((SPS > 1) ? 1 : 0);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state;
  logic [PW-1:0]             phase;
  logic [LW-1:0]             level;
  logic [AW-1:0]             wr_ptr, rd_ptr;
  logic [31:0]               mem [FIFO_DEPTH];
  logic [31:0]               head_p0;
  logic signed [DATA_W-1:0]  hold_i_p0, hold_q_p0;
  logic [31:0]               data_p1;
  logic                      vld_p1, uf_p1, ovf;

  logic empty, full, strobe_run, pop, push;

  assign head_p0    = mem[rd_ptr];
  assign empty      = (level == '0);
  assign full       = (level == DEPTH_L);
  assign strobe_run = (state == RUN) && i_sample_en;
  assign pop        = strobe_run && (phase == '0) && !empty;
  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  assign push       = i_valid && (!full || pop);

  // ---- p0: FIFO storage and symbol hold register (data path, no reset)
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_data;
    if (pop) {hold_i_p0, hold_q_p0} <= head_p0;
  end

  // ---- p1: control, occupancy and registered output sample
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      phase   <= '0;
      level   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      vld_p1  <= 1'b0;
      uf_p1   <= 1'b0;
      ovf     <= 1'b0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= strobe_run;
      uf_p1  <= strobe_run && (phase == '0) && empty;

      if (strobe_run) begin
        if (phase == '0) begin
          if (!empty) begin
            data_p1 <= head_p0;
            phase   <= PH_AFTER_LD;
          end else begin
            data_p1 <= '0;
            state   <= IDLE;
          end
        end else begin
          data_p1 <= (HOLD_MODE != 0) ? {hold_i_p0, hold_q_p0} : '0;
          phase   <= (phase == LAST_PH) ? '0 : phase + 1'b1;
        end
      end

      if (state == IDLE && level >= START_L) state <= RUN;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (i_valid && full && !pop) ovf <= 1'b1;
    end
  end

  assign o_data      = data_p1;
  assign o_valid     = vld_p1;
  assign o_underflow = uf_p1;
  assign o_overflow  = ovf;
  assign o_level     = level;

endmodule

// File: doc/qpsk_symbol_upsampler.md
Name: qpsk_symbol_upsampler

Overview:
- Sits directly downstream of the QPSK mapper and consumes its 32-bit symbol stream: bits [31:16] are I, bits [15:0] are Q, each 16-bit signed.
- Buffers the irregular symbol stream in a small FIFO.
- Re-emits each symbol at SPS samples per symbol on a DAC-rate sample strobe, by zero-stuffing or sample-and-hold, ready for the pulse-shaping filter.
- The mapper has no backpressure, so overflow and underflow are detected and flagged rather than stalled.

Parameters:
- SPS, 4: samples per symbol; legal range 1..16.
- FIFO_DEPTH, 8: symbol FIFO depth; power of two, 2..64.
- START_LEVEL, 2: FIFO occupancy required to leave IDLE; legal range 1..FIFO_DEPTH.
- HOLD_MODE, 0: 0 = zero-stuff (phases 1..SPS-1 output 0); 1 = hold (repeat symbol on every phase).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_data  in  32  symbol {I[15:0], Q[15:0]} from the mapper
- i_valid  in  1  i_data valid; one-cycle pulse per symbol
- i_sample_en  in  1  output sample strobe at DAC rate; any duty cycle up to every cycle
- o_data  out  32  output sample {I, Q}
- o_valid  out  1  o_data valid; one-cycle pulse
- o_underflow  out  1  one-cycle pulse when the FIFO runs dry in RUN
- o_overflow  out  1  sticky; set when a symbol is dropped on a full FIFO
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (i_reset=1 at posedge):
  - o_data=0, o_valid=0, o_underflow=0, o_overflow=0, o_level=0.
  - FIFO is emptied, phase counter=0, state=IDLE.
  - Reset overrides every other input in the same cycle.
  - Reset mid-symbol discards the current symbol and all buffered symbols.
- Write side:
  - i_valid=1 with level<FIFO_DEPTH: the symbol is written and level increments.
  - i_valid=1 with level==FIFO_DEPTH: the symbol is dropped, o_overflow is set, and it stays set until reset.
  - A newly written word becomes readable the cycle after it is written.
- Simultaneous write and read in the same cycle: both take effect; level is unchanged. This is allowed at full, because the read frees the slot in the same cycle.
- State IDLE:
  - o_valid stays 0 regardless of i_sample_en.
  - Moves to RUN when level>=START_LEVEL.
  - This is evaluated every cycle; the first sample comes on the next i_sample_en after entering RUN.
- State RUN, on each i_sample_en=1:
  - phase==0, FIFO non-empty: pop one symbol and load it into the hold register. o_data=symbol, o_valid=1. phase <= (SPS==1) ? 0 : 1.
  - phase==0, FIFO empty: o_data=0, o_valid=1, o_underflow=1 for that cycle. State goes to IDLE, phase stays 0.
  - phase!=0: o_data = hold register if HOLD_MODE=1, else 0. o_valid=1. phase <= (phase==SPS-1) ? 0 : phase+1.
  - Cycles without i_sample_en: o_valid=0, o_underflow=0, and phase and state are unchanged.
- Latency: o_data/o_valid are registered and appear on the cycle after the i_sample_en sample edge.
- o_data holds its last value when o_valid=0.
- Data width: samples pass through bit-exact; no arithmetic or scaling.
- Phase counter width is $clog2(SPS) with a minimum of 1 bit; wrap-around is at SPS-1.

Test Plan:
- Basic, zero-stuff:
  - Setup: SPS=4, HOLD_MODE=0, START_LEVEL=2, i_sample_en held high.
  - Stimulus: write 32'h5A815A81 then 32'hA57F5A81, one cycle apart.
  - Required: o_valid high every cycle from the first sample, in the sequence 5A815A81, 0, 0, 0, A57F5A81, 0, 0, 0.
  - Then a zero sample with o_underflow=1, then o_valid=0 (IDLE).
- Hold mode:
  - Setup: same stimulus with HOLD_MODE=1.
  - Required: 5A815A81 ×4, A57F5A81 ×4, then the underflow zero sample.
- Sparse strobe:
  - Setup: i_sample_en=1 every 3rd cycle.
  - Required: exactly one o_valid per strobe, one cycle after it.
  - Required: the phase sequence is identical to the first scenario; no samples on non-strobe cycles.
- Overflow:
  - Setup: i_sample_en=0.
  - Stimulus: write 9 symbols with FIFO_DEPTH=8.
  - Required: o_level=8, o_overflow=1 and sticky, and the 9th symbol is absent when the FIFO is drained afterward.
- Full plus simultaneous read/write: with the FIFO full, drive a write on the same cycle as a phase-0 pop -> o_level stays 8 and o_overflow stays 0.
- Reset mid-operation:
  - Stimulus: assert i_reset for 1 cycle during phase 2 with 3 symbols buffered.
  - Required next cycle: all outputs 0, o_level=0, IDLE.
  - Required: after 2 new writes, output restarts at phase 0 with the first new symbol.
